rom_burst_arbiter: RTL
======================

# rom_burst_arbiter

Two-port burst-read arbiter in front of a single synchronous weight/parameter ROM (1-cycle registered read, chip-select `csen`). Two requesters, e.g. the conv-layer and FC-layer weight fetchers, each post a (start address, length) burst. The block grants one burst at a time, round-robin on ties, and drives the ROM address/enable sequence. It returns each ROM word to the granted requester with a valid strobe and a last-word `done` pulse.

## Interface
- `DATA_WIDTH`, 8, ROM word width
- `ADDR_WIDTH`, 8, ROM address width
- `LEN_WIDTH`, 8, burst length field width; burst size = `len`+1 words

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  burst request pending
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high with valid
- `req0_addr` / `req1_addr`  in  ADDR_WIDTH  burst start address
- `req0_len` / `req1_len`  in  LEN_WIDTH  words minus one
- `rd0_valid` / `rd1_valid`  out  1  `rd*_data` holds a burst word this cycle
- `rd0_data` / `rd1_data`  out  DATA_WIDTH  ROM word; forced 0 when the matching valid is low
- `rd0_done` / `rd1_done`  out  1  1-cycle pulse coincident with last word's valid
- `rom_csen`  out  1  ROM chip select
- `rom_addr`  out  ADDR_WIDTH  ROM address
- `rom_data`  in  DATA_WIDTH  ROM registered output; high-Z while ROM in reset
- `busy`  out  1  state != IDLE
- `grant_id`  out  1  requester owning the current/last burst

## Operation
- States: IDLE, BURST, DRAIN.
- **IDLE:**
  - Arbitration is combinational on `req*_valid`. Exactly one `req*_ready` is high, that of the winner, and only if it is valid.
  - Only one valid: that requester wins.
  - Both valid: the requester other than `last_grant` wins. `last_grant` resets to 1, so requester 0 wins the first tie.
  - On handshake: latch addr into the address counter, latch len into the remaining counter, set `grant_id`, update `last_grant`, go to BURST.
- **BURST:**
  - `rom_csen`=1 and `rom_addr`=counter each cycle.
  - Counter increments modulo 2^ADDR_WIDTH; wrap from max to 0 is legal.
  - Remaining decrements.
  - After issuing the word with remaining==0, go to DRAIN.
- **DRAIN:**
  - `rom_csen`=0.
  - Wait one cycle for the final ROM word, then go to IDLE.
- **Return path:**
  - `issue_d` is `rom_csen` registered; `last_d` is "final issue" registered.
  - `rdN_valid` = `issue_d` & (`grant_id`==N).
  - `rdN_data` = `rdN_valid` ? `rom_data` : 0.
  - `rdN_done` = `rdN_valid` & `last_d`.
- Requests arriving while `busy` are held off: `ready`=0. Requesters must hold valid/addr/len stable until ready.
- `req*_ready` is never high outside IDLE.
- `rom_addr` holds its last value when `rom_csen`=0.

## Timing
- Handshake in cycle T:
  - ROM issues in cycles T+1 … T+1+len.
  - `rd_valid` in cycles T+2 … T+2+len, `done` at T+2+len.
  - DRAIN at T+2+len, IDLE at T+3+len.
  - Next handshake possible at T+3+len.
- Per-burst overhead: 2 idle ROM cycles (handshake cycle + drain cycle).
- Throughput within a burst: 1 word/cycle, no bubbles.
- Reset (asynchronous, any state, including mid-burst):
  - State → IDLE; `rom_csen`, `rom_addr`, `busy`, `grant_id` = 0.
  - `issue_d`, `last_d` = 0, so all `rd*_valid`/`rd*_done`/`rd*_data` = 0.
  - `req*_ready` = 0 while `rst_n` is low.
  - `last_grant` = 1.
  - An interrupted burst produces no `done` and is not resumed.
- No ready is asserted while `rst_n` is low. The first handshake is possible in the first clock with `rst_n` high.
- `rd*_data` is never X/Z while `rd*_valid` is low; this is required because the ROM output is Z in reset.

## Test plan
- **Single burst:** req0 addr=0x10, len=3 → `rom_addr` 0x10..0x13 with `csen` for 4 cycles starting T+1. `rd0_valid` 4 cycles carrying mem[0x10..0x13]; `rd0_done` with the 0x13 word. `rd1_valid` stays 0. Back in IDLE at T+6.
- **Tie + round-robin:** both valid from reset, req0 len=1, req1 len=0, held → req0 granted first. req1 handshakes at T+4 (T+3+len of req0's burst). Then, with both re-asserted, req0 wins again: `last_grant`=1 after req1 served.
- **len=0:** req1 addr=0x7F → one `csen` cycle, `rd1_valid` and `rd1_done` both high in the same single cycle, DRAIN, IDLE at T+3.
- **Address wrap:** req0 addr=0xFE, len=3 → `rom_addr` 0xFE, 0xFF, 0x00, 0x01; data matches mem in that order.
- **Reset mid-burst:** req0 addr=0x20, len=7; assert `rst_n`=0 during the 3rd issue cycle. Outputs go 0 immediately (asynchronously), no `rd0_done` ever. After release, req1 alone is granted normally with correct data.
- **Hold-off:** req1 asserts during req0's burst → `req1_ready` stays 0 until IDLE. Its burst starts the cycle after IDLE handshake with no data interleaving.

Source files
------------

// File: rtl/rom_burst_arbiter.sv
// Two-requester burst-read arbiter in front of a synchronous ROM with a 1-cycle
// registered read. Grants one burst at a time, round-robin on ties.
module rom_burst_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [LEN_WIDTH-1:0]  req0_len,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [LEN_WIDTH-1:0]  req1_len,
    output logic                  rd0_valid,
    output logic [DATA_WIDTH-1:0] rd0_data,
    output logic                  rd0_done,
    output logic                  rd1_valid,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  rd1_done,
    output logic                  rom_csen,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic                   last_grant;
    logic                   issue_d;
    logic                   last_d;

    logic                   any_valid;
    logic                   winner;
    logic                   handshake;
    logic                   final_issue;

    // Handshake: a request transfers in a cycle where its valid and ready are
    // both high; ready only rises in IDLE, out of reset, for the arbitration
    // winner, and the requester holds valid/addr/len stable until then.
    always_comb begin
        any_valid   = req0_valid | req1_valid;
        winner      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        handshake   = rst_n && (state == IDLE) && any_valid;
        req0_ready  = handshake && !winner;
        req1_ready  = handshake && winner;
        final_issue = (state == BURST) && (remaining == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            rom_csen   <= 1'b0;
            rom_addr   <= '0;
            issue_d    <= 1'b0;
            last_d     <= 1'b0;
        end else begin
            issue_d <= rom_csen;
            last_d  <= final_issue;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state      <= BURST;
                        rom_csen   <= 1'b1;
                        rom_addr   <= winner ? req1_addr : req0_addr;
                        remaining  <= winner ? req1_len : req0_len;
                        grant_id   <= winner;
                        last_grant <= winner;
                    end
                end
                BURST: begin
                    if (final_issue) begin
                        // rom_addr deliberately keeps the last issued address.
                        state    <= DRAIN;
                        rom_csen <= 1'b0;
                    end else begin
                        rom_addr  <= rom_addr + ADDR_ONE;
                        remaining <= remaining - LEN_ONE;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    rom_csen <= 1'b0;
                end
            endcase
        end
    end

    // Data is gated to zero when not valid so a floating ROM output never leaks.
    always_comb begin
        busy      = (state != IDLE);
        rd0_valid = issue_d && (grant_id == 1'b0);
        rd1_valid = issue_d && (grant_id == 1'b1);
        rd0_data  = rd0_valid ? rom_data : '0;
        rd1_data  = rd1_valid ? rom_data : '0;
        rd0_done  = rd0_valid && last_d;
        rd1_done  = rd1_valid && last_d;
    end

endmodule
